// File: rtl/axi_slave_mem.sv
// AXI-style burst slave backed by a DEPTH x SIZE*8 register memory.
// Write and read FSMs run concurrently; all handshake outputs are registered.
module axi_slave_mem #(
  parameter int SIZE  = 4,
  parameter int DEPTH = 16
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              awvalid,
  output logic              awready,
  input  logic [SIZE*8-1:0] awadd,
  input  logic [3:0]        awlen,
  input  logic [1:0]        awburst,
  input  logic              wvalid,
  output logic              wready,
  input  logic [SIZE*8-1:0] wdata,
  input  logic              wlast,
  output logic              bvalid,
  input  logic              bready,
  output logic [1:0]        bresp,
  input  logic              arvalid,
  output logic              aready,
  input  logic [SIZE*8-1:0] aradd,
  input  logic [3:0]        arlen,
  input  logic [1:0]        arburst,
  output logic              rvalid,
  input  logic              rready,
  output logic [SIZE*8-1:0] rdata,
  output logic              rlast,
  output logic [1:0]        rresp
);

  localparam int DW = SIZE * 8;
  localparam int SB = $clog2(SIZE);
  localparam int IB = $clog2(DEPTH);
  localparam logic [DW-1:0] MEM_BYTES = DW'(DEPTH * SIZE);

  localparam logic [1:0] B_FIXED = 2'd0;
  localparam logic [1:0] B_INCR  = 2'd1;
  localparam logic [1:0] B_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic R_IDLE = 1'b0;
  localparam logic R_DATA = 1'b1;

  // Reserved burst types and WRAP with a non power-of-two beat count run as INCR with SLVERR.
  function automatic logic f_bad_burst(input logic [3:0] len, input logic [1:0] burst);
    logic len_ok;
    len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    return (burst == 2'd3) || ((burst == B_WRAP) && !len_ok);
  endfunction

  function automatic logic [1:0] f_eff_burst(input logic [3:0] len, input logic [1:0] burst);
    return f_bad_burst(len, burst) ? B_INCR : burst;
  endfunction

  function automatic logic [DW-1:0] f_next_addr(input logic [DW-1:0] addr,
                                                input logic [3:0]    len,
                                                input logic [1:0]    burst);
    logic [DW-1:0] inc;
    logic [DW-1:0] win_mask;
    inc      = addr + DW'(SIZE);
    win_mask = ((DW'(len) + DW'(1)) * DW'(SIZE)) - DW'(1);
    case (burst)
      B_FIXED: return addr;
      B_WRAP:  return (addr & ~win_mask) | (inc & win_mask);
      default: return inc;
    endcase
  endfunction

  function automatic logic f_in_range(input logic [DW-1:0] addr);
    return addr < MEM_BYTES;
  endfunction

  function automatic logic [IB-1:0] f_idx(input logic [DW-1:0] addr);
    return addr[SB +: IB];
  endfunction

  logic [DW-1:0] r_mem [DEPTH];

  // Write path state
  logic [1:0]    r_wstate;
  logic [DW-1:0] r_waddr;
  logic [3:0]    r_wlen;
  logic [1:0]    r_wburst;
  logic [3:0]    r_wcnt;
  logic          r_werr;

  logic w_aw_bad, w_wr_in_range, w_wbeat, w_wcnt_hit, w_wfinal, w_werr_next, w_mem_we;

  assign w_aw_bad      = f_bad_burst(awlen, awburst);
  assign w_wr_in_range = f_in_range(r_waddr);
  assign w_wbeat       = (r_wstate == W_DATA) && wvalid && wready;
  assign w_wcnt_hit    = (r_wcnt == r_wlen);
  assign w_wfinal      = w_wcnt_hit || wlast;
  assign w_werr_next   = r_werr || !w_wr_in_range || (w_wfinal && (wlast != w_wcnt_hit));
  assign w_mem_we      = w_wbeat && w_wr_in_range;

  // NOTE: the storage array has no reset branch; contents survive areset and map to plain flops/RAM.
  always_ff @(posedge aclk) begin
    if (w_mem_we) r_mem[f_idx(r_waddr)] <= wdata;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wstate <= W_IDLE;
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wburst <= B_FIXED;
      r_wcnt   <= '0;
      r_werr   <= 1'b0;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (awvalid && awready) begin
            r_waddr  <= awadd;
            r_wlen   <= awlen;
            r_wburst <= f_eff_burst(awlen, awburst);
            r_wcnt   <= '0;
            r_werr   <= w_aw_bad;
            awready  <= 1'b0;
            wready   <= 1'b1;
            r_wstate <= W_DATA;
          end else begin
            awready  <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_wbeat) begin
            r_werr <= w_werr_next;
            if (w_wfinal) begin
              wready   <= 1'b0;
              bvalid   <= 1'b1;
              bresp    <= w_werr_next ? RESP_SLVERR : RESP_OKAY;
              r_wstate <= W_RESP;
            end else begin
              r_wcnt  <= r_wcnt + 4'd1;
              r_waddr <= f_next_addr(r_waddr, r_wlen, r_wburst);
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
            awready  <= 1'b1;
            r_wstate <= W_IDLE;
          end
        end
        default: begin
          awready  <= 1'b0;
          wready   <= 1'b0;
          bvalid   <= 1'b0;
          r_wstate <= W_IDLE;
        end
      endcase
    end
  end

  // Read path state
  logic          r_rstate;
  logic [DW-1:0] r_raddr;
  logic [3:0]    r_rlen;
  logic [1:0]    r_rburst;
  logic [3:0]    r_rcnt;
  logic          r_rerr;

  logic [DW-1:0] w_rd_addr, w_rd_word;
  logic          w_rd_in_range, w_ar_bad;

  // The same lookup serves the first beat (from aradd) and every later beat (next address).
  assign w_rd_addr     = (r_rstate == R_IDLE) ? aradd : f_next_addr(r_raddr, r_rlen, r_rburst);
  assign w_rd_in_range = f_in_range(w_rd_addr);
  assign w_rd_word     = w_rd_in_range ? r_mem[f_idx(w_rd_addr)] : '0;
  assign w_ar_bad      = f_bad_burst(arlen, arburst);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_rstate <= R_IDLE;
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rburst <= B_FIXED;
      r_rcnt   <= '0;
      r_rerr   <= 1'b0;
      aready   <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rlast    <= 1'b0;
      rresp    <= RESP_OKAY;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (arvalid && aready) begin
            r_raddr  <= aradd;
            r_rlen   <= arlen;
            r_rburst <= f_eff_burst(arlen, arburst);
            r_rcnt   <= '0;
            r_rerr   <= w_ar_bad;
            aready   <= 1'b0;
            rvalid   <= 1'b1;
            rdata    <= w_rd_word;
            rlast    <= (arlen == 4'd0);
            rresp    <= (w_ar_bad || !w_rd_in_range) ? RESP_SLVERR : RESP_OKAY;
            r_rstate <= R_DATA;
          end else begin
            aready   <= 1'b1;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast) begin
              rvalid   <= 1'b0;
              rdata    <= '0;
              rlast    <= 1'b0;
              rresp    <= RESP_OKAY;
              aready   <= 1'b1;
              r_rstate <= R_IDLE;
            end else begin
              r_raddr <= w_rd_addr;
              r_rcnt  <= r_rcnt + 4'd1;
              rdata   <= w_rd_word;
              rlast   <= ((r_rcnt + 4'd1) == r_rlen);
              rresp   <= (r_rerr || !w_rd_in_range) ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Self-checking bench for axi_slave_mem: directed vector table, hand-written
// corner sequences, and randomized bursts checked against a word-array model.
module tb_axi_slave_mem;

  localparam int SIZE  = 4;
  localparam int DEPTH = 16;
  localparam int MEMB  = SIZE * DEPTH;
  localparam int TMO   = 50;

  logic        aclk, areset;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awadd, wdata, aradd, rdata;
  logic [3:0]  awlen, arlen;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        arvalid, aready, rvalid, rready, rlast;

  axi_slave_mem #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .aclk(aclk), .areset(areset),
    .awvalid(awvalid), .awready(awready), .awadd(awadd), .awlen(awlen), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .aready(aready), .aradd(aradd), .arlen(arlen), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast), .rresp(rresp)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: word array plus beat-address rules computed arithmetically.
  logic [31:0] model_mem [DEPTH];
  logic [31:0] wbuf [16];

  function automatic bit m_bad(input logic [3:0] len, input logic [1:0] b);
    return (b == 2'd3) || (b == 2'd2 && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));
  endfunction

  function automatic logic [31:0] m_addr(input logic [31:0] a, input logic [3:0] len,
                                         input logic [1:0] b, input int i);
    int unsigned win, base;
    if (m_bad(len, b) || b == 2'd1) return a + 32'(i * SIZE);
    if (b == 2'd0) return a;
    win  = (int'(len) + 1) * SIZE;
    base = (a / win) * win;
    return base + ((a - base + 32'(i * SIZE)) % win);
  endfunction

  task automatic send_aw(input logic [31:0] a, input logic [3:0] len, input logic [1:0] b);
    int n = 0;
    awadd = a; awlen = len; awburst = b; awvalid = 1'b1;
    while (!awready && n < TMO) begin @(negedge aclk); n++; end
    if (n >= TMO) check("awready_timeout", 0, 1);
    @(negedge aclk);
    awvalid = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last);
    int n = 0;
    wdata = d; wlast = last; wvalid = 1'b1;
    while (!wready && n < TMO) begin @(negedge aclk); n++; end
    if (n >= TMO) check("wready_timeout", 0, 1);
    @(negedge aclk);
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic finish_b(input logic [1:0] exp, input int bdly);
    check("bvalid_after_last", 64'(bvalid), 1);
    check("bresp", 64'(bresp), 64'(exp));
    for (int d = 0; d < bdly; d++) begin
      @(negedge aclk);
      check("b_hold", 64'({bvalid, bresp}), 64'({1'b1, exp}));
    end
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    check("b_done", 64'({bvalid, awready}), 64'({1'b0, 1'b1}));
  endtask

  // wl = index of the beat carrying wlast; wl > len means wlast is never asserted.
  task automatic do_write(input logic [31:0] a, input logic [3:0] len, input logic [1:0] b,
                          input int wl, input logic [1:0] exp, input int bdly);
    int nb;
    logic [31:0] ba;
    send_aw(a, len, b);
    nb = ((wl < int'(len)) ? wl : int'(len)) + 1;
    for (int i = 0; i < nb; i++) begin
      send_beat(wbuf[i], i == wl);
      ba = m_addr(a, len, b, i);
      if (ba < MEMB) model_mem[ba / SIZE] = wbuf[i];
    end
    finish_b(exp, bdly);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] len, input logic [1:0] b,
                         input int stall_at, input int stall_n);
    int n = 0;
    logic [31:0] ba, ed;
    logic [1:0]  er;
    aradd = a; arlen = len; arburst = b; arvalid = 1'b1;
    while (!aready && n < TMO) begin @(negedge aclk); n++; end
    if (n >= TMO) check("aready_timeout", 0, 1);
    @(negedge aclk);
    arvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      ba = m_addr(a, len, b, i);
      ed = (ba < MEMB) ? model_mem[ba / SIZE] : 32'h0;
      er = (m_bad(len, b) || ba >= MEMB) ? 2'b10 : 2'b00;
      check("rbeat", {28'h0, rvalid, rlast, rresp, rdata}, {28'h0, 1'b1, i == int'(len), er, ed});
      if (i == stall_at) begin
        for (int k = 0; k < stall_n; k++) begin
          @(negedge aclk);
          check("r_hold", {28'h0, rvalid, rlast, rresp, rdata}, {28'h0, 1'b1, i == int'(len), er, ed});
        end
      end
      rready = 1'b1;
      @(negedge aclk);
      rready = 1'b0;
    end
    check("r_done", 64'({rvalid, aready}), 64'({1'b0, 1'b1}));
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [1:0]  burst;
    int          wl;
    logic [31:0] dbase;
    int          bdly;
    int          rstall_at;
    int          rstall_n;
    logic [1:0]  exp_bresp;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [31:0] old_v, ba;
    logic [3:0]  len;
    logic [1:0]  b;
    logic [31:0] a;
    int          wl, nb;
    bit          oor;

    vecs[0] = '{32'h00, 4'd3,  2'd1, 3,  32'hA0,  5, 1, 3, 2'b00};
    vecs[1] = '{32'h00, 4'd15, 2'd1, 15, 32'h100, 0, -1, 0, 2'b00};
    vecs[2] = '{32'h08, 4'd3,  2'd2, 3,  32'h1,   0, -1, 0, 2'b00};
    vecs[3] = '{32'h20, 4'd3,  2'd1, 1,  32'h50,  2, -1, 0, 2'b10};
    vecs[4] = '{32'h3C, 4'd1,  2'd1, 1,  32'h60,  0, 1, 2, 2'b10};
    vecs[5] = '{32'h10, 4'd2,  2'd2, 2,  32'h70,  0, -1, 0, 2'b10};
    vecs[6] = '{32'h30, 4'd1,  2'd3, 1,  32'h80,  0, -1, 0, 2'b10};
    vecs[7] = '{32'h24, 4'd2,  2'd0, 2,  32'h90,  1, 0, 1, 2'b00};
    vecs[8] = '{32'h1D, 4'd0,  2'd1, 0,  32'hB0,  0, -1, 0, 2'b00};

    awvalid = 0; awadd = 0; awlen = 0; awburst = 0;
    wvalid = 0; wdata = 0; wlast = 0; bready = 0;
    arvalid = 0; aradd = 0; arlen = 0; arburst = 0; rready = 0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 'x;

    areset = 1'b1;
    #3;
    check("reset_outs", 64'({awready, wready, bvalid, bresp, aready, rvalid, rlast, rresp}), 0);
    check("reset_rdata", 64'(rdata), 0);
    @(negedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    check("ready_after_reset", 64'({awready, aready, wready}), 64'({1'b1, 1'b1, 1'b0}));

    // Directed vector table
    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < 16; i++) wbuf[i] = vecs[v].dbase + 32'(i);
      do_write(vecs[v].addr, vecs[v].len, vecs[v].burst, vecs[v].wl, vecs[v].exp_bresp, vecs[v].bdly);
      do_read(vecs[v].addr, vecs[v].len, vecs[v].burst, vecs[v].rstall_at, vecs[v].rstall_n);
    end
    do_read(32'h40, 4'd0, 2'd1, -1, 0);
    do_read(32'h00, 4'd15, 2'd1, 7, 3);

    // Write and read of word 5 land on the same edge: read must see the old value
    old_v = model_mem[5];
    send_aw(32'h14, 4'd0, 2'd1);
    wvalid = 1'b1; wdata = 32'hDEAD_BEEF; wlast = 1'b1;
    arvalid = 1'b1; aradd = 32'h14; arlen = 4'd0; arburst = 2'd1;
    check("concurrent_ready", 64'({wready, aready}), 64'({1'b1, 1'b1}));
    @(negedge aclk);
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    model_mem[5] = 32'hDEAD_BEEF;
    check("concurrent_rdata_old", 64'(rdata), 64'(old_v));
    check("concurrent_r_b", 64'({rvalid, rlast, rresp, bvalid, bresp}), 64'({1'b1, 1'b1, 2'b00, 1'b1, 2'b00}));
    bready = 1'b1; rready = 1'b1;
    @(negedge aclk);
    bready = 1'b0; rready = 1'b0;
    check("concurrent_done", 64'({bvalid, rvalid}), 0);
    do_read(32'h14, 4'd0, 2'd1, -1, 0);

    // Reset asserted mid-write abandons the burst; memory keeps written beats
    send_aw(32'h28, 4'd3, 2'd1);
    send_beat(32'hC0, 1'b0); model_mem[10] = 32'hC0;
    send_beat(32'hC1, 1'b0); model_mem[11] = 32'hC1;
    #2 areset = 1'b1;
    #1;
    check("async_reset_outs", 64'({awready, wready, bvalid, bresp, aready, rvalid, rlast, rresp}), 0);
    @(negedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    check("ready_after_midreset", 64'({awready, aready, wready, bvalid}), 64'({1'b1, 1'b1, 1'b0, 1'b0}));
    for (int i = 0; i < 16; i++) wbuf[i] = 32'hE0 + 32'(i);
    do_write(32'h28, 4'd3, 2'd1, 3, 2'b00, 0);
    do_read(32'h20, 4'd7, 2'd1, -1, 0);

    // Randomized bursts against the model
    for (int t = 0; t < 40; t++) begin
      a   = 32'($urandom_range(0, 71));
      len = 4'($urandom_range(0, 15));
      b   = 2'($urandom_range(0, 3));
      wl  = ($urandom_range(0, 1) == 1) ? int'(len) : int'($urandom_range(0, 16));
      for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
      nb  = ((wl < int'(len)) ? wl : int'(len)) + 1;
      oor = 1'b0;
      for (int i = 0; i < nb; i++) begin
        ba = m_addr(a, len, b, i);
        if (ba >= MEMB) oor = 1'b1;
      end
      do_write(a, len, b, wl, (m_bad(len, b) || oor || wl != int'(len)) ? 2'b10 : 2'b00,
               int'($urandom_range(0, 3)));
      do_read(32'($urandom_range(0, 71)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
